acq_write_ctrl: RTL and testbench

ACQ_WRITE_CTRL -- requirements
Module: acq_write_ctrl

---
 rtl/acq_pkg.sv | 7 +
 rtl/acq_delay_counter.sv | 19 +
 rtl/acq_write_ctrl.sv | 112 +++++++++++
 tb/tb_acq_write_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// acq_pkg: shared FSM state encoding and default widths for the acquisition write controller
package acq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_WRITE, S_WAIT} acq_state_t;
  localparam int ADDR_WIDTH_DEF   = 13;
  localparam int PERIOD_WIDTH_DEF = 16;
  localparam int DELAY_WIDTH_DEF  = 16;
endpackage

// File: rtl/acq_delay_counter.sv
// acq_delay_counter: loadable down-counter with zero flag
// ports: clk, rst (sync, active-high); i_load/i_val load the count; i_dec decrements; o_zero flags count==0
module acq_delay_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec) r_cnt <= r_cnt - W'(1);
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/acq_write_ctrl.sv
// acq_write_ctrl: sequences BRAM write bursts per acquisition period after a post-trigger delay
// ports: clk, rst (sync, active-high); restart arms and latches count_max/n_periods/delay;
//   end_cycle marks period boundaries; continuous rearms after the final period;
//   wen/addr/first/last drive the BRAM; period_idx, busy, done (pulse), overrun (sticky) report status
module acq_write_ctrl
  import acq_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
  parameter int DELAY_WIDTH  = DELAY_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restart,
  input  logic                    end_cycle,
  input  logic [ADDR_WIDTH-1:0]   count_max,
  input  logic [PERIOD_WIDTH-1:0] n_periods,
  input  logic [DELAY_WIDTH-1:0]  delay,
  input  logic                    continuous,
  output logic                    wen,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    first,
  output logic                    last,
  output logic [PERIOD_WIDTH-1:0] period_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  acq_state_t              r_state;
  logic [ADDR_WIDTH-1:0]   r_cm, r_addr;
  logic [PERIOD_WIDTH-1:0] r_np, r_pidx;
  logic [DELAY_WIDTH-1:0]  r_delay;
  logic                    r_wen, r_first, r_last, r_busy, r_done, r_overrun;
  logic [ADDR_WIDTH-1:0]   w_addr_nx;
  logic [PERIOD_WIDTH-1:0] w_last_pidx;
  logic                    w_final, w_go, w_zero, w_start, w_load;
  // n_periods==0 behaves as a single period
  assign w_last_pidx = (r_np == '0) ? '0 : r_np - PERIOD_WIDTH'(1);
  assign w_final     = (r_pidx == w_last_pidx);
  assign w_addr_nx   = r_addr + ADDR_WIDTH'(1);
  assign w_go        = end_cycle && (r_state == S_ARMED || r_state == S_WAIT);
  assign w_start     = (w_go && r_delay == '0) || (r_state == S_DELAY && w_zero);
  // counter holds delay-1 so the first write lands delay cycles after the boundary
  assign w_load      = !restart && w_go && r_delay != '0;
  acq_delay_counter #(.W(DELAY_WIDTH)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (r_state == S_DELAY && !w_zero),
    .i_val  (r_delay - DELAY_WIDTH'(1)),
    .o_zero (w_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= S_IDLE;
      r_cm      <= '0;
      r_np      <= '0;
      r_delay   <= '0;
      r_addr    <= '0;
      r_pidx    <= '0;
      r_wen     <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= !restart && (r_overrun || (end_cycle && (r_state == S_DELAY || r_state == S_WRITE)));
      if (restart) begin
        r_cm    <= count_max;
        r_np    <= n_periods;
        r_delay <= delay;
        r_pidx  <= '0;
        r_addr  <= '0;
        r_wen   <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= S_ARMED;
      end else if (w_start) begin
        r_state <= S_WRITE;
        r_wen   <= 1'b1;
        r_addr  <= '0;
        r_first <= (r_pidx == '0);
        r_last  <= w_final && r_cm == '0;
      end else if (w_go) begin
        r_state <= S_DELAY;
      end else if (r_state == S_WRITE) begin
        if (r_addr == r_cm) begin
          r_wen   <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= w_final;
          r_pidx  <= w_final ? (continuous ? '0 : r_pidx) : r_pidx + PERIOD_WIDTH'(1);
          r_state <= (w_final && !continuous) ? S_IDLE : S_WAIT;
          r_busy  <= !(w_final && !continuous);
        end else begin
          r_addr <= w_addr_nx;
          r_last <= w_final && w_addr_nx == r_cm;
        end
      end
    end
  assign wen        = r_wen;
  assign addr       = r_addr;
  assign first      = r_first;
  assign last       = r_last;
  assign period_idx = r_pidx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_acq_write_ctrl.sv
// tb_acq_write_ctrl: scoreboard bench for acq_write_ctrl with directed vectors
module tb_acq_write_ctrl;
  logic        clk, rst, restart, end_cycle, continuous;
  logic [12:0] count_max, addr;
  logic [15:0] n_periods, delay, period_idx;
  logic        wen, first, last, busy, done, overrun;
  int cyc = 0, n_pass = 0, n_tot = 0, t;
  typedef struct {bit dn; int cyc; int addr; bit f; bit l; int p;} exp_t;
  exp_t q[$];
  exp_t me;
  acq_write_ctrl dut (
    .clk(clk), .rst(rst), .restart(restart), .end_cycle(end_cycle),
    .count_max(count_max), .n_periods(n_periods), .delay(delay), .continuous(continuous),
    .wen(wen), .addr(addr), .first(first), .last(last), .period_idx(period_idx),
    .busy(busy), .done(done), .overrun(overrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (wen === 1'b1 || done === 1'b1) begin
      n_tot++;
      if (q.size() == 0)
        $display("FAIL unexpected_output cyc=%0d wen=%b done=%b addr=%0d, required no output", cyc, wen, done, addr);
      else begin
        me = q.pop_front();
        if (me.dn == done && wen == !me.dn && me.cyc == cyc &&
            (me.dn || (int'(addr) == me.addr && first == me.f && last == me.l && int'(period_idx) == me.p)))
          n_pass++;
        else
          $display("FAIL %s got cyc=%0d wen=%b done=%b addr=%0d first=%b last=%b pidx=%0d, required cyc=%0d addr=%0d first=%b last=%b pidx=%0d",
                   me.dn ? "done_pulse" : "write", cyc, wen, done, addr, first, last, period_idx,
                   me.cyc, me.addr, me.f, me.l, me.p);
      end
    end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s got=%0d required=%0d", nm, act, exp_v);
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic restart_pulse();
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
  endtask
  task automatic end_pulse(output int tt);
    end_cycle = 1'b1;
    tt = cyc;
    idle(1);
    end_cycle = 1'b0;
  endtask
  task automatic exp_writes(int tt, int d, int cm, int p, int n, int cnt);
    for (int a = 0; a < cnt; a++)
      q.push_back('{dn: 1'b0, cyc: tt + 1 + d + a, addr: a, f: (p == 0), l: (a == cm && p == n - 1), p: p});
  endtask
  task automatic exp_done(int c);
    q.push_back('{dn: 1'b1, cyc: c, addr: 0, f: 1'b0, l: 1'b0, p: 0});
  endtask
  initial begin
    rst = 1'b1; restart = 1'b0; end_cycle = 1'b0; continuous = 1'b0;
    count_max = '0; n_periods = '0; delay = '0;
    idle(3);
    chk("rst_flags", {26'd0, wen, first, last, done, busy, overrun}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_pidx", period_idx, 0);
    rst = 1'b0;
    end_pulse(t);
    idle(2);
    chk("idle_end_no_overrun", overrun, 0);
    chk("idle_end_not_busy", busy, 0);
    // single period, no delay; count_max changed after arming must be ignored
    count_max = 13'd7; n_periods = 16'd1; delay = 16'd0;
    restart_pulse();
    chk("armed_busy", busy, 1);
    count_max = 13'd2;
    end_pulse(t);
    exp_writes(t, 0, 7, 0, 1, 8);
    exp_done(t + 9);
    idle(10);
    chk("single_busy_after", busy, 0);
    chk("single_no_overrun", overrun, 0);
    // three periods with delay 5
    count_max = 13'd3; n_periods = 16'd3; delay = 16'd5;
    restart_pulse();
    for (int p = 0; p < 3; p++) begin
      end_pulse(t);
      exp_writes(t, 5, 3, p, 3, 4);
      if (p == 2) exp_done(t + 10);
      idle(19);
    end
    chk("multi_busy_after", busy, 0);
    chk("multi_pidx_end", period_idx, 2);
    // end_cycle during a burst
    count_max = 13'd15; n_periods = 16'd1; delay = 16'd0;
    restart_pulse();
    end_pulse(t);
    exp_writes(t, 0, 15, 0, 1, 16);
    exp_done(t + 17);
    idle(1);
    end_pulse(t);
    idle(1);
    chk("overrun_set", overrun, 1);
    idle(16);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_burst_done", busy, 0);
    restart_pulse();
    chk("overrun_cleared", overrun, 0);
    // continuous mode, two periods per acquisition
    count_max = 13'd1; n_periods = 16'd2; delay = 16'd0; continuous = 1'b1;
    restart_pulse();
    for (int k = 0; k < 4; k++) begin
      end_pulse(t);
      exp_writes(t, 0, 1, k % 2, 2, 2);
      if (k % 2 == 1) exp_done(t + 3);
      idle(5);
    end
    chk("cont_still_busy", busy, 1);
    chk("cont_pidx_wrapped", period_idx, 0);
    continuous = 1'b0;
    // n_periods=0, count_max=0
    count_max = 13'd0; n_periods = 16'd0; delay = 16'd0;
    restart_pulse();
    end_pulse(t);
    exp_writes(t, 0, 0, 0, 1, 1);
    exp_done(t + 2);
    idle(3);
    chk("np0_busy_after", busy, 0);
    // reset mid-burst at addr 4
    count_max = 13'd15; n_periods = 16'd1;
    restart_pulse();
    end_pulse(t);
    exp_writes(t, 0, 15, 0, 1, 5);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_wen", wen, 0);
    chk("rst_mid_addr", addr, 0);
    chk("rst_mid_busy", busy, 0);
    idle(3);
    chk("rst_mid_no_done", done, 0);
    // restart during a burst
    restart_pulse();
    end_pulse(t);
    exp_writes(t, 0, 15, 0, 1, 3);
    idle(2);
    restart_pulse();
    chk("restart_write_wen", wen, 0);
    chk("restart_write_busy", busy, 1);
    // restart coinciding with end_cycle
    count_max = 13'd0;
    restart = 1'b1; end_cycle = 1'b1;
    idle(1);
    restart = 1'b0; end_cycle = 1'b0;
    idle(2);
    chk("restart_wins_wen", wen, 0);
    chk("restart_wins_busy", busy, 1);
    end_pulse(t);
    exp_writes(t, 0, 0, 0, 1, 1);
    exp_done(t + 2);
    idle(4);
    chk("final_busy", busy, 0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
